// File: rtl/fix_pkg.sv
// ---------------------------------------------------------------------------
// fix_pkg: shared definitions for the 4.23 fixed-point datapath.
//   FIX_WIDTH / FIX_FRAC : default word width and fraction bits.
//   FIX_MAX / FIX_MIN    : saturation values (+7.99999988 / -8.0).
//   state_t              : control states for sequential operators.
// Used by the multiplier, divider and computation-node code.
// ---------------------------------------------------------------------------
package fix_pkg;

  localparam int FIX_WIDTH = 27;
  localparam int FIX_FRAC  = 23;

  localparam logic [FIX_WIDTH-1:0] FIX_MAX = 27'h3FF_FFFF;
  localparam logic [FIX_WIDTH-1:0] FIX_MIN = 27'h400_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage : fix_pkg

// File: rtl/div_step.sv
// ---------------------------------------------------------------------------
// div_step: one combinational restoring-division step.
//   rem_i     : partial remainder before the step
//   divisor_i : unsigned divisor magnitude
//   bit_i     : next dividend bit shifted into the remainder
//   rem_o     : partial remainder after the step
//   q_o       : quotient bit produced by this step
// ---------------------------------------------------------------------------
module div_step #(
  parameter int RW = 28,  // remainder width
  parameter int DW = 27   // divisor width, DW <= RW
) (
  input  logic [RW-1:0] rem_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          bit_i,
  output logic [RW-1:0] rem_o,
  output logic          q_o
);

  logic [RW:0]   shifted;
  logic [RW-1:0] diff;

  // NOTE: every output of a combinational block gets a value on every path
  // (here by straight-line assignment) so no latch is inferred.
  always_comb begin
    shifted = {rem_i, bit_i};
    q_o     = (shifted >= (RW+1)'(divisor_i));
    // When q_o is set the true difference is below the divisor, so the low
    // RW bits hold it exactly.
    diff    = shifted[RW-1:0] - RW'(divisor_i);
    rem_o   = q_o ? diff : shifted[RW-1:0];
  end

endmodule : div_step

// File: rtl/signed_div.sv
// ---------------------------------------------------------------------------
// signed_div: sequential signed 4.23 fixed-point divider, quotient = a / b.
// One restoring step per clock, fixed latency, truncation toward zero,
// saturation on overflow and divide-by-zero.
//   clk      : rising-edge clock
//   reset_n  : synchronous active-low reset
//   start    : request, accepted only in IDLE or DONE
//   a, b     : signed dividend / divisor, latched on an accepted start
//   busy     : high during RUN and FIX
//   done     : one-cycle pulse when quotient/ovf/div0 are updated
//   quotient : signed 4.23 result, held until the next done
//   ovf      : |quotient| would reach 8.0; result saturated
//   div0     : divisor was zero; result saturated
// ---------------------------------------------------------------------------
module signed_div
  import fix_pkg::*;
#(
  parameter int WIDTH = FIX_WIDTH,
  parameter int FRAC  = FIX_FRAC
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic             ovf,
  output logic             div0
);

  localparam int IW = WIDTH - 1 - FRAC;   // integer bits
  localparam int QW = WIDTH - 1;          // quotient magnitude bits / steps
  localparam int RW = WIDTH + 1;          // remainder width
  localparam int DW = WIDTH + FRAC;       // scaled dividend width
  localparam int CW = $clog2(QW);

  localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state_q, state_d;

  // Operand preparation (used only on an accepted start).
  logic             accept;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [DW-1:0]    dividend;
  logic             ovf_pre_c;

  // Datapath registers.
  logic             sign_q, a_neg_q, div0_pre_q, ovf_pre_q;
  logic [WIDTH-1:0] b_abs_q;
  logic [RW-1:0]    rem_q;
  logic [QW-1:0]    shift_q;
  logic [QW-1:0]    mag_q;
  logic [CW-1:0]    cnt_q;

  logic [RW-1:0]    step_rem;
  logic             step_q;

  // Result registers.
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic             ovf_q, ovf_d, div0_q, div0_d;

  assign accept = start && (state_q == IDLE || state_q == DONE);

  // Magnitudes as unsigned WIDTH-bit values; -8.0 maps to 2^(WIDTH-1).
  always_comb begin
    a_abs     = a[WIDTH-1] ? -a : a;
    b_abs     = b[WIDTH-1] ? -b : b;
    dividend  = {a_abs, FRAC'(0)};
    // The quotient reaches 8.0 exactly when |a| >= |b| * 2^IW.
    ovf_pre_c = ({IW'(0), a_abs} >= {b_abs, IW'(0)});
  end

  div_step #(.RW(RW), .DW(WIDTH)) u_step (
    .rem_i     (rem_q),
    .divisor_i (b_abs_q),
    .bit_i     (shift_q[QW-1]),
    .rem_o     (step_rem),
    .q_o       (step_q)
  );

  // ---- FSM: state register ----
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // ---- FSM: next state ----
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == '0) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---- FSM: outputs ----
  always_comb begin
    busy = (state_q == RUN) || (state_q == FIX);
    done = (state_q == DONE);
  end

  // ---- Datapath ----
  // NOTE: these registers carry no reset: they are always loaded on an
  // accepted start before they are used, so their reset value is irrelevant.
  always_ff @(posedge clk) begin
    if (accept) begin
      sign_q     <= a[WIDTH-1] ^ b[WIDTH-1];
      a_neg_q    <= a[WIDTH-1];
      div0_pre_q <= (b == '0);
      ovf_pre_q  <= ovf_pre_c;
      b_abs_q    <= b_abs;
      rem_q      <= RW'(dividend[DW-1:WIDTH-1]);
      shift_q    <= dividend[WIDTH-2:0];
      mag_q      <= '0;
      cnt_q      <= CW'(WIDTH - 2);
    end else if (state_q == RUN) begin
      // Full step count always runs, even for div0/overflow, to keep latency fixed.
      rem_q   <= step_rem;
      shift_q <= {shift_q[QW-2:0], 1'b0};
      mag_q   <= {mag_q[QW-2:0], step_q};
      cnt_q   <= cnt_q - CW'(1);
    end
  end

  // Result rules applied in FIX.
  always_comb begin
    quotient_d = sign_q ? -{1'b0, mag_q} : {1'b0, mag_q};
    ovf_d      = 1'b0;
    div0_d     = 1'b0;
    if (div0_pre_q) begin
      quotient_d = a_neg_q ? SAT_MIN : SAT_MAX;
      div0_d     = 1'b1;
    end else if (ovf_pre_q) begin
      quotient_d = sign_q ? SAT_MIN : SAT_MAX;
      ovf_d      = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      quotient_q <= '0;
      ovf_q      <= 1'b0;
      div0_q     <= 1'b0;
    end else if (state_q == FIX) begin
      quotient_q <= quotient_d;
      ovf_q      <= ovf_d;
      div0_q     <= div0_d;
    end
  end

  assign quotient = quotient_q;
  assign ovf      = ovf_q;
  assign div0     = div0_q;

endmodule : signed_div

// File: tb/tb_signed_div.sv
// ---------------------------------------------------------------------------
// tb_signed_div: directed self-checking bench for signed_div.
// ---------------------------------------------------------------------------
module tb_signed_div;
  import fix_pkg::*;

  localparam int W = FIX_WIDTH;

  logic         clk = 1'b0;
  logic         reset_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         busy, done, ovf, div0;
  logic [W-1:0] quotient;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  signed_div #(.WIDTH(W), .FRAC(FIX_FRAC)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .quotient (quotient),
    .ovf      (ovf),
    .div0     (div0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge with start already driven. Counts posedges starting
  // with the one that samples start, until done is seen (bounded). Pulses a
  // junk start request after posedge p1 and p2.
  task automatic wait_done(input int p1, input int p2, output int n, output logic busy_ok);
    n = 0;
    busy_ok = 1'b1;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start = (n == p1) || (n == p2);
      if (start) begin
        a = 27'h0800000;   // 1.0 / 0.125 would overflow if it were accepted
        b = 27'h0100000;
      end
      if (!done && !busy) busy_ok = 1'b0;
    end while (!done && n < 60);
  endtask

  task automatic run(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                     input logic [W-1:0] eq, input logic eovf, input logic ediv0,
                     input logic b2b, input int p1, input int p2);
    int   n;
    logic bok;
    if (!b2b) @(negedge clk);
    a = av;
    b = bv;
    start = 1'b1;
    wait_done(p1, p2, n, bok);
    start = 1'b0;
    check($sformatf("%s latency", tag), n, 28);
    check($sformatf("%s busy_run", tag), bok, 1);
    check($sformatf("%s busy_done", tag), busy, 0);
    check($sformatf("%s quotient", tag), quotient, eq);
    check($sformatf("%s ovf", tag), ovf, eovf);
    check($sformatf("%s div0", tag), div0, ediv0);
  endtask

  initial begin
    int dones;

    reset_n = 1'b0;
    start   = 1'b0;
    a       = '0;
    b       = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst quotient", quotient, 0);
    check("rst ovf", ovf, 0);
    check("rst div0", div0, 0);
    reset_n = 1'b1;

    // Main function
    run("1.5/0.5",   27'h0C00000, 27'h0400000, 27'h1800000, 0, 0, 0, -1, -1);
    run("-1/4",      27'h7800000, 27'h2000000, 27'h7E00000, 0, 0, 0, -1, -1);
    run("1/3",       27'h0800000, 27'h1800000, 27'h02AAAAA, 0, 0, 0, -1, -1);
    run("-1/3",      27'h7800000, 27'h1800000, 27'h7D55556, 0, 0, 0, -1, -1);
    run("7.5/1",     27'h3C00000, 27'h0800000, 27'h3C00000, 0, 0, 0, -1, -1);
    run("-8/2",      27'h4000000, 27'h1000000, 27'h6000000, 0, 0, 0, -1, -1);

    // Overflow
    run("4/0.25",    27'h2000000, 27'h0200000, FIX_MAX, 1, 0, 0, -1, -1);
    run("-4/0.5",    27'h6000000, 27'h0400000, FIX_MIN, 1, 0, 0, -1, -1);
    run("-8/-1",     27'h4000000, 27'h7800000, FIX_MAX, 1, 0, 0, -1, -1);

    // Divide by zero
    run("-1/0",      27'h7800000, 27'h0000000, FIX_MIN, 0, 1, 0, -1, -1);
    run("0/0",       27'h0000000, 27'h0000000, FIX_MAX, 0, 1, 0, -1, -1);

    // start during RUN is ignored
    run("ignore",    27'h0C00000, 27'h0400000, 27'h1800000, 0, 0, 0, 5, 15);

    // Back-to-back: second start held in the DONE cycle
    run("b2b_first", 27'h0800000, 27'h1800000, 27'h02AAAAA, 0, 0, 0, -1, -1);
    run("b2b_second", 27'h7800000, 27'h2000000, 27'h7E00000, 0, 0, 1, -1, -1);

    // Quotient holds while idle
    repeat (5) @(negedge clk);
    check("hold quotient", quotient, 27'h7E00000);
    check("hold done", done, 0);
    check("hold busy", busy, 0);

    // Reset during RUN: set div0 first so reset clearing is visible
    run("pre_rst",   27'h7800000, 27'h0000000, FIX_MIN, 0, 1, 0, -1, -1);
    @(negedge clk);
    a = 27'h0800000;
    b = 27'h1800000;
    start = 1'b1;
    repeat (10) begin
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
    end
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort ovf", ovf, 0);
    check("abort div0", div0, 0);
    reset_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    check("abort no_done", dones, 0);
    run("post_rst",  27'h7800000, 27'h1800000, 27'h7D55556, 0, 0, 0, -1, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_signed_div
